// File: rtl/brew_timer.sv
// brew_timer: seconds countdown for the coffee-maker FSM.
// A prescaler divides clk down to a one-second tick, and a seconds counter runs
// down from a preset chosen by length_time. Expiry is held as a level until the
// FSM releases start_timer.
module brew_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int LEN0     = 2,
  parameter int LEN1     = 4,
  parameter int LEN2     = 6,
  parameter int LEN3     = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_timer_i,
  input  logic [1:0]       length_time_i,
  output logic             t_expired_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] secs_left_o
);

  // Prescaler width: it has to hold TICK_DIV-1. Keep at least one bit so that
  // TICK_DIV=1 still builds; in that case the prescaler stays at 0 and every
  // RUN cycle is a tick.
  localparam int               PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] secs_q, secs_d;
  logic             start_dly_q;
  logic             armed_q;
  logic             busy_q;
  logic             t_expired_q;
  logic             start_edge;
  logic [CNT_W-1:0] len_sel;

  // Only the first cycle after reset needs armed_q. start_dly_q comes out of
  // reset at 0, so a start_timer that was already high would otherwise look
  // like a rising edge. A new start is accepted only after start_timer has been
  // seen low at least once.
  assign start_edge = start_timer_i & ~start_dly_q & armed_q;

  // Select the preset. It is only consumed when a start is accepted, which
  // latches it into secs_q; later changes to length_time have no effect.
  always_comb begin
    len_sel = CNT_W'(LEN0);
    case (length_time_i)
      2'd0:    len_sel = CNT_W'(LEN0);
      2'd1:    len_sel = CNT_W'(LEN1);
      2'd2:    len_sel = CNT_W'(LEN2);
      default: len_sel = CNT_W'(LEN3);
    endcase
  end

  // Next-state logic. In RUN, an abort takes precedence over the final tick.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    secs_d  = secs_q;
    case (state_q)
      S_IDLE: begin
        secs_d = '0;
        if (start_edge) begin
          if (len_sel == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            secs_d  = len_sel;
            pre_d   = PRE_RELOAD;
          end
        end
      end
      S_RUN: begin
        if (!start_timer_i) begin
          state_d = S_IDLE;
          secs_d  = '0;
        end else if (pre_q != '0) begin
          pre_d = pre_q - PRE_W'(1);
        end else if (secs_q <= CNT_W'(1)) begin
          // Catch 0 here as well so that the counter can never wrap.
          state_d = S_DONE;
          secs_d  = '0;
        end else begin
          secs_d = secs_q - CNT_W'(1);
          pre_d  = PRE_RELOAD;
        end
      end
      S_DONE: begin
        secs_d = '0;
        if (!start_timer_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        secs_d  = '0;
      end
    endcase
  end

  // State, counters, and the registered Moore outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      secs_q      <= '0;
      start_dly_q <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      t_expired_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      secs_q      <= secs_d;
      start_dly_q <= start_timer_i;
      armed_q     <= armed_q | ~start_timer_i;
      busy_q      <= (state_d == S_RUN);
      t_expired_q <= (state_d == S_DONE);
    end
  end

  assign busy_o      = busy_q;
  assign t_expired_o = t_expired_q;
  assign secs_left_o = secs_q;

endmodule

// File: tb/tb_brew_timer.sv
// Testbench for brew_timer with TICK_DIV=4 and LEN0..3 = 2,4,6,8.
// The reference model tracks how many clock edges have passed since the start
// was accepted, and derives the remaining seconds and the expiry point from
// that count with plain arithmetic.
module tb_brew_timer;

  localparam int TD    = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_timer = 1'b0;
  logic [1:0]       length_time = 2'd0;
  logic             t_expired;
  logic             busy;
  logic [CNT_W-1:0] secs_left;

  brew_timer #(
    .TICK_DIV(TD), .LEN0(2), .LEN1(4), .LEN2(6), .LEN3(8), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_timer_i(start_timer),
    .length_time_i(length_time),
    .t_expired_o  (t_expired),
    .busy_o       (busy),
    .secs_left_o  (secs_left)
  );

  always #5 clk = ~clk;

  int checks_run = 0;
  int fail_count = 0;

  // Reference model. m_mode: 0 = idle, 1 = running, 2 = expired.
  int lens[4] = '{2, 4, 6, 8};
  int m_mode  = 0;
  int m_len   = 0;
  int m_n     = 0;
  bit m_prev  = 1'b0;
  bit m_armed = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_run++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_n     = 0;
    m_len   = 0;
    m_prev  = 1'b0;
    m_armed = 1'b0;
  endtask

  // Apply one clock edge to the model, using the inputs sampled at that edge.
  task automatic model_step(input bit s, input logic [1:0] lt);
    case (m_mode)
      0: if (s && !m_prev && m_armed) begin
           m_len = lens[lt];
           m_n   = 0;
           m_mode = (m_len == 0) ? 2 : 1;
         end
      1: if (!s) m_mode = 0;
         else begin
           m_n++;
           if (m_n == m_len * TD) m_mode = 2;
         end
      default: if (!s) m_mode = 0;
    endcase
    m_prev  = s;
    m_armed = m_armed | !s;
  endtask

  task automatic check_outputs(input string tag);
    int exp_secs;
    exp_secs = (m_mode == 1) ? (m_len - m_n / TD) : 0;
    check_val({tag, "_busy"}, 32'(busy), 32'(m_mode == 1));
    check_val({tag, "_exp"},  32'(t_expired), 32'(m_mode == 2));
    check_val({tag, "_secs"}, 32'(secs_left), 32'(exp_secs));
  endtask

  // One clock cycle: drive on the falling edge, clock the model at the rising
  // edge, and compare 1 ns later.
  task automatic step(input bit s, input logic [1:0] lt, input string tag);
    @(negedge clk);
    start_timer = s;
    length_time = lt;
    @(posedge clk);
    model_step(s, lt);
    #1;
    check_outputs(tag);
  endtask

  // Assert reset asynchronously mid-cycle, check the outputs at once, and release on a falling edge.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int first_exp;
  bit seen_exp;
  bit rs;

  initial begin
    // Reset state
    rst_n = 1'b0;
    #12;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'd1, "idle");
    step(1'b0, 2'd1, "idle");

    // 1: length 1 -> expiry 16 edges after the start edge
    step(1'b1, 2'd1, "s1_start");
    check_val("s1_busy_k1", 32'(busy), 32'd1);
    check_val("s1_secs_k1", 32'(secs_left), 32'd4);
    first_exp = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 2'd1, "s1_run");
      if (t_expired && first_exp < 0) first_exp = i;
    end
    check_val("s1_latency", 32'(first_exp), 32'd16);

    // 2: held high after expiry, then dropped, then restarted
    for (int i = 0; i < 5; i++) step(1'b1, 2'd1, "s2_hold");
    check_val("s2_still_exp", 32'(t_expired), 32'd1);
    step(1'b0, 2'd1, "s2_drop");
    check_val("s2_released", 32'(t_expired), 32'd0);
    step(1'b1, 2'd2, "s2_restart");
    check_val("s2_busy_again", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 2'd2, "s2_run");
    step(1'b0, 2'd2, "s2_abort");

    // 3: length 0, dropped during RUN cycle 5
    step(1'b1, 2'd0, "s3_start");
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, "s3_run");
    step(1'b0, 2'd0, "s3_drop");
    check_val("s3_idle_secs", 32'(secs_left), 32'd0);
    check_val("s3_no_exp", 32'(t_expired), 32'd0);
    step(1'b0, 2'd0, "s3_idle");

    // 4: length 3 with length_time changing mid-run
    step(1'b1, 2'd3, "s4_start");
    first_exp = -1;
    for (int i = 1; i <= 36; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), "s4_run");
      if (t_expired && first_exp < 0) first_exp = i;
    end
    check_val("s4_latency", 32'(first_exp), 32'd32);
    step(1'b0, 2'd0, "s4_drop");

    // 5: length 2, async reset at RUN cycle 10, start held high afterwards
    step(1'b1, 2'd2, "s5_start");
    for (int i = 0; i < 9; i++) step(1'b1, 2'd2, "s5_run");
    pulse_reset("s5_rst");
    seen_exp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 2'd2, "s5_held");
      if (t_expired || busy) seen_exp = 1'b1;
    end
    check_val("s5_no_retrigger", 32'(seen_exp), 32'd0);
    step(1'b0, 2'd2, "s5_drop");

    // 6: length 0, start dropped exactly on the final tick edge (k+8)
    step(1'b1, 2'd0, "s6_start");
    for (int i = 0; i < 7; i++) step(1'b1, 2'd0, "s6_run");
    check_val("s6_secs_last", 32'(secs_left), 32'd1);
    step(1'b0, 2'd0, "s6_final");
    check_val("s6_no_exp", 32'(t_expired), 32'd0);
    check_val("s6_idle", 32'(busy), 32'd0);

    // Random stimulus: level-style start with occasional toggles, random
    // length changes, and rare asynchronous resets.
    rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) rs = ~rs;
      if ($urandom_range(0, 499) == 0) pulse_reset("rnd_rst");
      step(rs, 2'($urandom_range(0, 3)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks_run, fail_count);
    $finish;
  end

endmodule
